fetch_buffer: RTL and testbench

//  Instruction-fetch initiator for the single-cycle rom/memory request interface.

---
 rtl/fetch_buffer_if.sv | 36 +++
 rtl/fetch_buffer.sv | 150 +++++++++++++++
 tb/tb_fetch_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Bundles the fetch initiator's memory request port, redirect input and
// decode-side instruction queue port into one connection.
interface fetch_buffer_if;
    // memory request / response
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    // front-end redirect (branch / trap)
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    // decode-side queue head
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    // fetch_buffer side
    modport master (
        output mem_valid, mem_instr, mem_addr,
        input  mem_rdata, mem_ready,
        input  redirect_valid, redirect_addr,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    // memory / core side
    modport slave (
        input  mem_valid, mem_instr, mem_addr,
        output mem_rdata, mem_ready,
        output redirect_valid, redirect_addr,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch initiator: issues one word-aligned request at a time and
// queues returned words with their PC in a DEPTH-entry FIFO for decode.
// A redirect flushes the queue and discards any response still in flight.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clock,
    input  logic           reset,
    fetch_buffer_if.master bus
);
    localparam int unsigned    AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pc;
    logic          r_drop;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_wr_ptr;
    logic [31:0]   r_mem_data [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic [AW:0]   w_count;
    logic [AW:0]   w_count_after_pop;
    logic [AW:0]   w_count_next;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_resp;

    // Queue occupancy; the extra pointer MSB separates full from empty.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (r_rd_ptr[AW] != r_wr_ptr[AW]) &&
                     (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]);

    // A response completes the outstanding request only while waiting for it.
    assign w_resp = (r_state == S_WAIT) && bus.mem_ready;

    // A redirect flushes the queue that cycle, so neither a pop nor a push counts.
    assign w_pop  = !w_empty && bus.instr_ready && !bus.redirect_valid;
    assign w_push = w_resp && !r_drop && !bus.redirect_valid && (!w_full || w_pop);

    assign w_count_after_pop = w_count - (AW + 1)'(w_pop);
    assign w_count_next      = bus.redirect_valid ? '0
                             : w_count_after_pop + (AW + 1)'(w_push);

    // Request port: one-cycle strobe in REQ, address is the current fetch PC.
    assign bus.mem_valid = (r_state == S_REQ);
    assign bus.mem_instr = 1'b1;
    assign bus.mem_addr  = r_pc;

    // Queue head presented straight from storage; stable until popped.
    assign bus.instr_valid = !w_empty;
    assign bus.instr_data  = r_mem_data[r_rd_ptr[AW-1:0]];
    assign bus.instr_pc    = r_mem_pc[r_rd_ptr[AW-1:0]];

    // State register for the request sequencer.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: issue only while a queue slot is free for the response.
    always_comb begin
        // NOTE: the default up front covers every path, so no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!bus.redirect_valid && (w_count_after_pop < FULL_COUNT)) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_next = (w_count_next < FULL_COUNT) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Fetch PC and the flag that discards a response made stale by a redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_drop <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc   <= bus.redirect_addr & ~32'h3;
            r_drop <= (r_state == S_REQ) || ((r_state == S_WAIT) && !bus.mem_ready);
        end else if (w_resp) begin
            if (!r_drop) begin
                r_pc <= r_pc + 32'd4;
            end
            r_drop <= 1'b0;
        end
    end

    // Queue pointers; a flush empties the queue by catching rd up to wr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Queue storage: returned word paired with the PC it was fetched from.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: storage is reset so the head outputs read zero during reset.
        if (!reset) begin
            r_mem_data <= '{default: '0};
            r_mem_pc   <= '{default: '0};
        end else if (w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= bus.mem_rdata;
            r_mem_pc[r_wr_ptr[AW-1:0]]   <= r_pc;
        end
    end

    // A response strobe outside WAIT is a responder protocol error.
    a_ready_only_in_wait: assert property (
        @(posedge clock) disable iff (!reset) bus.mem_ready |-> (r_state == S_WAIT)
    );
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: startup latency, back-pressure, queue wrap,
// redirect in WAIT and REQ, reset mid-request and a random-latency responder.
module tb_fetch_buffer;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_buffer_if bus ();

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Memory model: word at byte address a.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h4101_4081 + (a >> 2) * 32'h0100_0100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Responder: acts on the falling edge, answers resp_delay cycles after the strobe.
    int          resp_delay = 1;
    bit          resp_rand  = 1'b0;
    int          overlap    = 0;
    bit          pending;
    int          cnt;
    logic [31:0] paddr;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        pending = 1'b0;
        cnt     = 0;
        paddr   = '0;
        forever begin
            @(negedge clock);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            if (!reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = mem_word(paddr);
                        pending       = 1'b0;
                    end
                end
                if (bus.mem_valid) begin
                    if (pending) overlap++;
                    pending = 1'b1;
                    paddr   = bus.mem_addr;
                    cnt     = resp_rand ? int'($urandom_range(1, 5)) : resp_delay;
                end
            end
        end
    end

    int          pulses;
    logic [31:0] last_addr;
    int          k;
    logic [31:0] exp_pc;

    initial begin
        reset              = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_mem_valid",   32'(bus.mem_valid),   32'h0);
        check("rst_mem_instr",   32'(bus.mem_instr),   32'h1);
        check("rst_mem_addr",    bus.mem_addr,         32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr_data",  bus.instr_data,       32'h0);
        check("rst_instr_pc",    bus.instr_pc,         32'h0);

        // 1: startup, one-cycle responder, consumer always ready
        step();
        reset = 1'b1;
        step();
        check("t1_req0_valid", 32'(bus.mem_valid), 32'h1);
        check("t1_req0_addr",  bus.mem_addr,       32'h0);
        step();
        check("t1_wait_valid", 32'(bus.mem_valid), 32'h0);
        step();
        check("t1_iv0",        32'(bus.instr_valid), 32'h1);
        check("t1_data0",      bus.instr_data,       32'h4101_4081);
        check("t1_pc0",        bus.instr_pc,         32'h0);
        check("t1_req1_addr",  bus.mem_addr,         32'h4);
        check("t1_req1_valid", 32'(bus.mem_valid),   32'h1);
        step();
        check("t1_popped", 32'(bus.instr_valid), 32'h0);
        step();
        check("t1_iv1",    32'(bus.instr_valid), 32'h1);
        check("t1_data1",  bus.instr_data,       32'h4201_4181);
        check("t1_pc1",    bus.instr_pc,         32'h4);

        // 2: consumer stalled -> exactly four requests, then one pop frees one slot
        reset           = 1'b0;
        bus.instr_ready = 1'b0;
        step();
        reset = 1'b1;
        pulses    = 0;
        last_addr = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_valid) begin
                pulses++;
                last_addr = bus.mem_addr;
            end
        end
        check("t2_pulses",     32'(pulses),          32'd4);
        check("t2_last_addr",  last_addr,            32'hC);
        check("t2_idle",       32'(bus.mem_valid),   32'h0);
        check("t2_head_pc",    bus.instr_pc,         32'h0);
        check("t2_head_data",  bus.instr_data,       32'h4101_4081);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check("t2_refill_valid", 32'(bus.mem_valid), 32'h1);
        check("t2_refill_addr",  bus.mem_addr,       32'h10);
        check("t2_head_pc1",     bus.instr_pc,       32'h4);
        check("t2_head_data1",   bus.instr_data,     32'h4201_4181);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_valid) pulses++;
        end
        check("t2_no_more_req", 32'(pulses), 32'd0);

        // 4: drain a full queue while it refills; order and pc kept across wrap
        bus.instr_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 100 && k < 8; i++) begin
            if (bus.instr_valid) begin
                check("t4_pc",   bus.instr_pc,   32'h4 + 32'(k) * 32'h4);
                check("t4_data", bus.instr_data, mem_word(32'h4 + 32'(k) * 32'h4));
                k++;
            end
            step();
        end
        check("t4_pops", 32'(k), 32'd8);
        bus.instr_ready = 1'b0;

        // 3: redirect while waiting, then redirect during a request (pc wrap)
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        step();
        resp_delay = 3;
        step();
        check("t3_wait_valid", 32'(bus.mem_valid),   32'h0);
        check("t3_pre_iv",     32'(bus.instr_valid), 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h5E;
        step();
        bus.redirect_valid = 1'b0;
        check("t3_flushed", 32'(bus.instr_valid), 32'h0);
        step();
        check("t3_no_push", 32'(bus.instr_valid), 32'h0);
        step();
        check("t3_new_valid", 32'(bus.mem_valid),   32'h1);
        check("t3_new_addr",  bus.mem_addr,         32'h5C);
        check("t3_dropped",   32'(bus.instr_valid), 32'h0);
        resp_delay = 1;
        step();
        step();
        check("t3_iv",   32'(bus.instr_valid), 32'h1);
        check("t3_pc",   bus.instr_pc,         32'h5C);
        check("t3_data", bus.instr_data,       32'h5801_5781);
        check("t3_req60_valid", 32'(bus.mem_valid), 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        check("t3r_flushed", 32'(bus.instr_valid), 32'h0);
        check("t3r_wait",    32'(bus.mem_valid),   32'h0);
        step();
        check("t3r_req_valid", 32'(bus.mem_valid),   32'h1);
        check("t3r_req_addr",  bus.mem_addr,         32'hFFFF_FFFC);
        check("t3r_no_push",   32'(bus.instr_valid), 32'h0);
        step();
        step();
        check("t3r_pc",    bus.instr_pc,   32'hFFFF_FFFC);
        check("t3r_data",  bus.instr_data, 32'h4001_3F81);
        check("t3r_wrap",  bus.mem_addr,   32'h0);

        // 5: reset in the middle of a pending request
        resp_delay = 3;
        step();
        reset = 1'b0;
        #1;
        check("t5_mem_valid",   32'(bus.mem_valid),   32'h0);
        check("t5_mem_addr",    bus.mem_addr,         32'h0);
        check("t5_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("t5_instr_data",  bus.instr_data,       32'h0);
        check("t5_instr_pc",    bus.instr_pc,         32'h0);
        step();
        step();
        step();
        check("t5_hold_valid", 32'(bus.mem_valid), 32'h0);
        resp_delay      = 1;
        bus.instr_ready = 1'b1;
        reset           = 1'b1;
        step();
        check("t5_first_valid", 32'(bus.mem_valid), 32'h1);
        check("t5_first_addr",  bus.mem_addr,       32'h0);
        step();
        step();
        check("t5_iv",   32'(bus.instr_valid), 32'h1);
        check("t5_pc",   bus.instr_pc,         32'h0);
        check("t5_data", bus.instr_data,       32'h4101_4081);
        step();
        check("t5_no_stale", 32'(bus.instr_valid), 32'h0);

        // 6: random responder latency and random consumer stalls
        resp_rand = 1'b1;
        exp_pc    = 32'h4;
        k         = 0;
        for (int i = 0; i < 3000 && k < 30; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if (bus.instr_valid && bus.instr_ready) begin
                check("t6_pc",   bus.instr_pc,   exp_pc);
                check("t6_data", bus.instr_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'h4;
                k++;
            end
            step();
        end
        check("t6_pops",       32'(k),       32'd30);
        check("t6_no_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
